// File: rtl/iob_gpio_pulse_gen.sv
// Programmable pulse-train transmitter: N active-high pulses of `hi` cycles per `per`-cycle period.
// All outputs registered; start/stop are single-cycle strobes, no backpressure.
module iob_gpio_pulse_gen #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] high_i,
  input  logic [NP_W-1:0]  npulses_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic [NP_W-1:0]  sent_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] per;
  logic [CNT_W-1:0] hi;
  logic [NP_W-1:0]  np;
  logic [NP_W-1:0]  sent;
  logic             pulse_q;
  logic             done_q;
  logic             cfg_err_q;

  logic             cfg_ok;
  logic [NP_W-1:0]  sent_nxt;
  logic             high_end;
  logic             period_end;

  assign cfg_ok     = (high_i != '0) && (period_i > high_i);
  assign sent_nxt   = sent + NP_W'(1);
  assign high_end   = (phase_cnt == hi - CNT_W'(1));
  assign period_end = (phase_cnt == per - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      per       <= '0;
      hi        <= '0;
      np        <= '0;
      sent      <= '0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state)
        IDLE: begin
          // A simultaneous stop suppresses the start entirely, including cfg_err.
          if (start_i && !stop_i) begin
            if (cfg_ok) begin
              per       <= period_i;
              hi        <= high_i;
              np        <= npulses_i;
              sent      <= '0;
              phase_cnt <= '0;
              pulse_q   <= 1'b1;
              state     <= HIGH;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (stop_i) begin
            state     <= IDLE;
            pulse_q   <= 1'b0;
            done_q    <= 1'b1;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
            if (high_end) begin
              pulse_q <= 1'b0;
              state   <= LOW;
            end
          end
        end
        LOW: begin
          if (stop_i) begin
            state     <= IDLE;
            done_q    <= 1'b1;
            phase_cnt <= '0;
          end else if (period_end) begin
            sent      <= sent_nxt;
            phase_cnt <= '0;
            if ((np != '0) && (sent_nxt == np)) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              pulse_q <= 1'b1;
              state   <= HIGH;
            end
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_o   = pulse_q;
  assign busy_o    = (state != IDLE);
  assign done_o    = done_q;
  assign cfg_err_o = cfg_err_q;
  assign sent_o    = sent;

endmodule

// File: doc/iob_gpio_pulse_gen.md
# iob_gpio_pulse_gen

Programmable pulse-train transmitter for the GPIO peripheral: the output-side counterpart of the sensor capture path. It drives one GPIO line with a configured number of active-high pulses, each a fixed number of cycles high within a fixed period, and reports progress to software. Configuration arrives from the GPIO software register file. `pulse_o` is muxed onto a `gpio_output` bit at the peripheral top level.

## Interface

Parameters:
- `CNT_W`, 16, width of period/high-time counters (cycles).
- `NP_W`, 16, width of pulse-count registers.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  one-cycle start strobe (SW register write enable).
- `stop_i`  in  1  one-cycle abort strobe.
- `period_i`  in  CNT_W  pulse period in cycles; sampled at accepted start.
- `high_i`  in  CNT_W  high time in cycles; sampled at accepted start.
- `npulses_i`  in  NP_W  pulses to send; 0 = continuous until stop.
- `pulse_o`  out  1  generated waveform, registered.
- `busy_o`  out  1  high while a train is in progress.
- `done_o`  out  1  one-cycle strobe when a train ends (completion or stop).
- `cfg_err_o`  out  1  one-cycle strobe when a start is rejected.
- `sent_o`  out  NP_W  completed periods in current/last train.

## Operation

- States: IDLE, HIGH, LOW. Internal `phase_cnt` (CNT_W), latched `per`, `hi`, `np`.
- IDLE, `start_i`=1, `stop_i`=0:
  - Config valid (`high_i`≥1 and `period_i`>`high_i`): latch config, clear `sent_o`, `phase_cnt`=0, go HIGH.
  - Config invalid: stay IDLE, pulse `cfg_err_o`, `sent_o` unchanged.
- HIGH: `pulse_o`=1. Increment `phase_cnt` each cycle. When `phase_cnt`=`hi`-1, go LOW.
- LOW: `pulse_o`=0. Continue counting. When `phase_cnt`=`per`-1:
  - `sent_o`++ (wraps modulo 2^NP_W; only reachable in continuous mode).
  - Reset `phase_cnt` to 0.
  - If `np`≠0 and `sent_o`+1=`np`: go IDLE and pulse `done_o`. Otherwise go HIGH.
- `stop_i` in HIGH or LOW: go IDLE next cycle, `pulse_o`=0 next cycle (truncates the current pulse), pulse `done_o`. `sent_o` holds completed periods only.
- `stop_i` in IDLE: no effect, no `done_o`.
- `start_i` in HIGH/LOW: ignored, with or without stop. `start_i`+`stop_i` together in IDLE: stop wins; start ignored, no `cfg_err_o`.
- Input changes after an accepted start do not affect the running train.
- `busy_o` = (state≠IDLE).
- Reset: state IDLE; `pulse_o`=0, `busy_o`=0, `done_o`=0, `cfg_err_o`=0, `sent_o`=0, `phase_cnt`=0. A reset mid-train aborts it without a `done_o` strobe.

## Timing

- Start sampled at edge E. `pulse_o` and `busy_o` are 1 from cycle E+1, for exactly `hi` cycles. Then `pulse_o` is 0 for `per`-`hi` cycles.
- Rising edges of `pulse_o` are exactly `per` cycles apart. No gap between consecutive periods.
- Final period: `done_o`=1 and `busy_o`=0 in the cycle after the last LOW cycle. A new start is accepted in that same cycle.
- `cfg_err_o` is asserted in cycle E+1.
- Stop sampled at edge S: `pulse_o`=0, `busy_o`=0, `done_o`=1 in cycle S+1.
- `sent_o` updates in the cycle after the last LOW cycle of each period.

## Test plan

- Reset mid-train (`per`=4, `hi`=2, `np`=0, `rst` after 10 cycles) -> all outputs 0 the cycle after `rst`; no `done_o`.
- `per`=5, `hi`=2, `np`=3, start -> three pulses, each 2 high/3 low, rising edges at E+1, E+6, E+11. `done_o` at E+16, `sent_o`=3, `busy_o` high for 15 cycles.
- Invalid configs: `hi`=0; `per`=`hi`=4 -> `cfg_err_o` one cycle, `busy_o` stays 0, `pulse_o` stays 0.
- Continuous mode (`per`=3, `hi`=1, `np`=0) for 30 cycles, then stop during HIGH -> `sent_o`=10 when stop is sampled. `pulse_o` and `busy_o` are 0 next cycle with a one-cycle `done_o`.
- Retrigger checks, `per`=2, `hi`=1, `np`=2:
  - Start during busy -> ignored.
  - Start+stop in IDLE -> nothing starts.
  - Start in the `done_o` cycle -> new train; first rising edge the next cycle.
- Change `period_i`/`high_i` mid-train -> waveform keeps the latched values.
